// File: rtl/pqc_pkg.sv
// Shared types and constants for the post-quantum arithmetic blocks.
package pqc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned KYBER_Q     = 3329;
    localparam int unsigned DILITHIUM_Q = 8380417;

endpackage

// File: rtl/mod_sub_step.sv
// One restoring-remainder step: shift in a dividend bit, subtract q if it fits.
module mod_sub_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] r,
    input  logic                  bit_in,
    input  logic [DATA_WIDTH-1:0] q,
    output logic [DATA_WIDTH-1:0] r_next
);

    logic [DATA_WIDTH:0] t;
    logic                fits;

    always_comb begin
        t    = {r, bit_in};
        fits = (t >= {1'b0, q});
        // Low bits of t - q are exact when t >= q, since the result is < q.
        r_next = fits ? (t[DATA_WIDTH-1:0] - q) : t[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/mod_reduce.sv
// Bit-serial x mod q: one remainder bit per cycle, start/output_ready pulse handshake.
module mod_reduce
    import pqc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] inp_value,
    input  logic [DATA_WIDTH-1:0] modulus,
    output logic                  busy,
    output logic                  output_ready,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  err
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                state, next_state;
    logic [DATA_WIDTH-1:0] x, q, r, r_next;
    logic [IDX_W-1:0]      bit_idx;

    mod_sub_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
        .r      (r),
        .bit_in (x[bit_idx]),
        .q      (q),
        .r_next (r_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (bit_idx == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x            <= '0;
            q            <= '0;
            r            <= '0;
            bit_idx      <= '0;
            output_ready <= 1'b0;
            out_value    <= '0;
            err          <= 1'b0;
        end else begin
            output_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x       <= inp_value;
                        q       <= modulus;
                        r       <= '0;
                        bit_idx <= IDX_W'(DATA_WIDTH - 1);
                    end
                end
                RUN: begin
                    r       <= r_next;
                    bit_idx <= bit_idx - 1'b1;
                end
                DONE: begin
                    // A zero modulus passes the dividend through and flags it.
                    if (q == '0) begin
                        out_value <= x;
                        err       <= 1'b1;
                    end else begin
                        out_value <= r;
                        err       <= 1'b0;
                    end
                    output_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce.sv
// Randomized scoreboard bench for mod_reduce against a plain x % q model.
module tb_mod_reduce;
    import pqc_pkg::*;

    localparam int DW  = 32;
    localparam int LAT = DW + 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] inp_value = '0;
    logic [DW-1:0] modulus = '0;
    logic          busy, output_ready, err;
    logic [DW-1:0] out_value;

    mod_reduce #(.DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .inp_value    (inp_value),
        .modulus      (modulus),
        .busy         (busy),
        .output_ready (output_ready),
        .out_value    (out_value),
        .err          (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] val;
        logic          e;
        longint        cyc;
    } exp_t;

    exp_t   sbq[$];
    longint cyc = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] xv, input logic [DW-1:0] qv, input longint due);
        exp_t e;
        e.val = (qv == 0) ? xv : xv % qv;
        e.e   = (qv == 0);
        e.cyc = due;
        return e;
    endfunction

    // Monitor: every output_ready pulse must match the oldest outstanding request.
    always @(negedge clock) begin
        if (reset_n && output_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_value", out_value, e.val);
                check("err", err, e.e);
                check("latency_cycle", cyc, e.cyc);
                check("busy_in_ready", busy, 0);
            end
        end
    end

    task automatic issue(input logic [DW-1:0] xv, input logic [DW-1:0] qv);
        int guard = 0;
        @(posedge clock); #1;
        while (busy && guard < 200) begin
            @(posedge clock); #1;
            guard++;
        end
        if (busy) check("issue_timeout", 1, 0);
        start     = 1'b1;
        inp_value = xv;
        modulus   = qv;
        sbq.push_back(model(xv, qv, cyc + LAT));
        @(posedge clock); #1;
        start     = 1'b0;
        inp_value = $urandom;
        modulus   = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (sbq.size() != 0 && guard < 300) begin
            @(posedge clock);
            guard++;
        end
        if (sbq.size() != 0) begin
            check("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
        @(posedge clock); #1;
    endtask

    function automatic logic [DW-1:0] rand_q();
        case ($urandom_range(0, 6))
            0:       return DW'(KYBER_Q);
            1:       return DW'(DILITHIUM_Q);
            2:       return DW'($urandom_range(1, 16));
            3:       return '1;
            4:       return '0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [DW-1:0] qv, xv;

        repeat (3) @(posedge clock);
        #1;
        check("reset_out_value", out_value, 0);
        check("reset_ready", output_ready, 0);
        check("reset_err", err, 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;

        // Directed cases
        issue(32'd123456789, DW'(KYBER_Q));
        check("busy_after_start", busy, 1);
        drain();
        issue(32'd3328, DW'(KYBER_Q));
        issue(32'd3329, DW'(KYBER_Q));
        issue(32'd0, DW'(KYBER_Q));
        issue(32'd987654, 32'd1);
        issue(32'hFFFF_FFFF, DW'(DILITHIUM_Q));
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(32'd55, 32'd0);
        issue(32'd3330, DW'(KYBER_Q));
        drain();

        // Start pulsed mid-RUN must be ignored
        issue(32'd1000000, DW'(KYBER_Q));
        repeat (5) @(posedge clock);
        #1;
        start = 1'b1; inp_value = 32'd77; modulus = 32'd5;
        @(posedge clock); #1;
        start = 1'b0;
        drain();

        // Start held high: one result every LAT cycles
        @(posedge clock); #1;
        start = 1'b1; inp_value = 32'd424242; modulus = DW'(DILITHIUM_Q);
        for (int k = 1; k <= 3; k++)
            sbq.push_back(model(32'd424242, DW'(DILITHIUM_Q), cyc + k * LAT));
        repeat (75) @(posedge clock);
        #1;
        start = 1'b0;
        drain();

        // Reset in the middle of RUN aborts the request
        issue(32'hDEAD_BEEF, 32'd12345);
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_out_value", out_value, 0);
        check("abort_ready", output_ready, 0);
        check("abort_err", err, 0);
        check("abort_busy", busy, 0);
        sbq.delete();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clock);
        issue(32'hDEAD_BEEF, 32'd12345);
        drain();

        // Randomized traffic, issued back to back
        for (int i = 0; i < 150; i++) begin
            qv = rand_q();
            case ($urandom_range(0, 3))
                0:       xv = qv;
                1:       xv = qv - 1;
                default: xv = $urandom;
            endcase
            issue(xv, qv);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
